// File: rtl/seq_pkg.sv
// Shared definitions for the mode sequencer: mode encoding and default sizing.
package seq_pkg;

  typedef enum logic [1:0] {
    COUNT_UP   = 2'b00,
    ALT        = 2'b01,
    HOLD       = 2'b10,
    COUNT_DOWN = 2'b11
  } mode_e;

  localparam int DEF_MAX_COUNT = 16;
  localparam int DEF_WIDTH     = 5;

endpackage

// File: rtl/mode_sequencer_if.sv
// Control/status bundle of the mode sequencer.
// master drives the controls and observes the state; slave is the sequencer.
interface mode_sequencer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             en;
  mode_e            mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] state;
  logic             tc;
  logic             alt_flag;

  modport master (
    output en, mode, load, load_val,
    input  state, tc, alt_flag
  );

  modport slave (
    input  en, mode, load, load_val,
    output state, tc, alt_flag
  );

endinterface

// File: rtl/seq_next_state.sv
// Combinational next-state and terminal-count logic of the mode sequencer.
// Build option: define SEQ_DOWN_EN to give mode COUNT_DOWN its decrement
// behaviour; without it COUNT_DOWN is identical to HOLD and no decrementer exists.
module seq_next_state
  import seq_pkg::*;
#(
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WRAP      = 1
) (
  input  logic [WIDTH-1:0] i_state,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc_next
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ALT_V = WIDTH'(MAX_COUNT + 1);
  localparam logic [WIDTH-1:0] PRE_V = WIDTH'(MAX_COUNT - 1);

  // Next state for the selected mode; ALT_V is only reachable through ALT or load.
  always_comb begin
    o_next    = i_state;
    o_tc_next = 1'b0;
    case (i_mode)
      COUNT_UP: begin
        if (i_state == ALT_V) begin
          o_next = '0;
        end else if (i_state < MAX_V) begin
          o_next = i_state + WIDTH'(1);
          if ((WRAP == 0) && (i_state == PRE_V)) o_tc_next = 1'b1;
        end else if (i_state == MAX_V) begin
          if (WRAP != 0) begin
            o_next    = '0;
            o_tc_next = 1'b1;
          end
        end
      end
      ALT: begin
        if (i_state == ALT_V) o_next = MAX_V;
        else                  o_next = ALT_V;
      end
      HOLD: begin
        o_next = i_state;
      end
      COUNT_DOWN: begin
`ifdef SEQ_DOWN_EN
        if (i_state == ALT_V) begin
          o_next = MAX_V;
        end else if (i_state == '0) begin
          if (WRAP != 0) begin
            o_next    = MAX_V;
            o_tc_next = 1'b1;
          end
        end else if (i_state <= MAX_V) begin
          o_next = i_state - WIDTH'(1);
          if ((WRAP == 0) && (i_state == WIDTH'(1))) o_tc_next = 1'b1;
        end
`else
        o_next = i_state;
`endif
      end
      default: begin
        o_next = i_state;
      end
    endcase
  end

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: registered state/tc/alt_flag with load > enable priority.
// Counting range is 0..MAX_COUNT plus the ALT-only value MAX_COUNT+1.
// Build option: SEQ_DOWN_EN enables the COUNT_DOWN mode (see seq_next_state).
module mode_sequencer
  import seq_pkg::*;
#(
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WRAP      = 1
) (
  input  logic             clk,
  input  logic             reset,
  mode_sequencer_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ALT_V = WIDTH'(MAX_COUNT + 1);

  // The state must be able to hold MAX_COUNT+1 with headroom.
  if ((longint'(1) << WIDTH) <= (longint'(MAX_COUNT) + 1)) begin : g_bad_width
    $error("mode_sequencer: WIDTH too small for MAX_COUNT");
  end

  logic [WIDTH-1:0] r_state;
  logic             r_tc;
  logic             r_alt_flag;

  logic [WIDTH-1:0] w_next;
  logic             w_tc_next;
  logic [WIDTH-1:0] w_state_d;
  logic             w_tc_d;
  logic             w_alt_d;

  seq_next_state #(
    .MAX_COUNT (MAX_COUNT),
    .WIDTH     (WIDTH),
    .WRAP      (WRAP)
  ) u_next (
    .i_state   (r_state),
    .i_mode    (bus.mode),
    .o_next    (w_next),
    .o_tc_next (w_tc_next)
  );

  // Load beats enable; out-of-range load values collapse to 0.
  always_comb begin
    w_state_d = r_state;
    w_tc_d    = 1'b0;
    if (bus.load) begin
      w_state_d = (bus.load_val <= ALT_V) ? bus.load_val : '0;
    end else if (bus.en) begin
      w_state_d = w_next;
      w_tc_d    = w_tc_next;
    end
    w_alt_d = (bus.mode == ALT) && ((w_state_d == MAX_V) || (w_state_d == ALT_V));
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= '0;
      r_tc       <= 1'b0;
      r_alt_flag <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_tc       <= w_tc_d;
      r_alt_flag <= w_alt_d;
    end
  end

  assign bus.state    = r_state;
  assign bus.tc       = r_tc;
  assign bus.alt_flag = r_alt_flag;

endmodule
